// File: rtl/ysyx_24070017_ifu.sv
// rtl/ysyx_24070017_ifu.sv - instruction fetch unit: pc -> AR/R memory handshake -> inst valid/ready
// Four-state fetch FSM with registered handshake outputs, redirect flush and fault reporting.
module ysyx_24070017_ifu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_arready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              mem_rready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [CNT_W-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic                drop, drop_nx;
    logic [ADDR_W-1:0]   pc_q, pc_q_nx;
    logic [DATA_W-1:0]   inst_nx;
    logic [ADDR_W-1:0]   inst_pc_nx;
    logic                inst_fault_nx;
    logic [CNT_W-1:0]    fetch_cnt_nx;

    always_comb begin
        state_nx      = state;
        drop_nx       = drop;
        pc_q_nx       = pc_q;
        inst_nx       = inst;
        inst_pc_nx    = inst_pc;
        inst_fault_nx = inst_fault;
        fetch_cnt_nx  = fetch_cnt;
        case (state)
            IDLE: begin
                if (pc_valid && pc_ready) begin
                    pc_q_nx = pc;
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned fetch never touches memory; deliver a faulting slot.
                        inst_nx       = '0;
                        inst_pc_nx    = pc;
                        inst_fault_nx = 1'b1;
                        state_nx      = OUT;
                    end else begin
                        state_nx = AR;
                    end
                end
            end
            AR: begin
                if (flush) drop_nx = 1'b1;
                if (mem_arvalid && mem_arready) state_nx = R;
            end
            R: begin
                if (mem_rvalid && mem_rready) begin
                    if (drop || flush) begin
                        drop_nx  = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        inst_nx       = mem_rdata;
                        inst_pc_nx    = pc_q;
                        inst_fault_nx = (mem_rresp != 2'b00);
                        state_nx      = OUT;
                    end
                end else if (flush) begin
                    drop_nx = 1'b1;
                end
            end
            OUT: begin
                // Flush wins over a same-cycle consume, so the slot is not counted.
                if (flush) begin
                    state_nx = IDLE;
                end else if (inst_valid && inst_ready) begin
                    fetch_cnt_nx = fetch_cnt + 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs are flops decoded from the next state, so they read 0 right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            drop        <= 1'b0;
            pc_q        <= '0;
            inst        <= '0;
            inst_pc     <= '0;
            inst_fault  <= 1'b0;
            fetch_cnt   <= '0;
            pc_ready    <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            inst_valid  <= 1'b0;
        end else begin
            state       <= state_nx;
            drop        <= drop_nx;
            pc_q        <= pc_q_nx;
            inst        <= inst_nx;
            inst_pc     <= inst_pc_nx;
            inst_fault  <= inst_fault_nx;
            fetch_cnt   <= fetch_cnt_nx;
            pc_ready    <= (state_nx == IDLE);
            mem_arvalid <= (state_nx == AR);
            mem_rready  <= (state_nx == R);
            inst_valid  <= (state_nx == OUT);
        end
    end

    assign mem_araddr = pc_q;

endmodule
